// File: rtl/avg_pkg.sv
// Shared opcode, z-code and op-kind definitions for the AVG fetch/decode front end.
package avg_pkg;

  localparam logic [2:0] OPC_VCTR  = 3'd0;
  localparam logic [2:0] OPC_HALT  = 3'd1;
  localparam logic [2:0] OPC_SVEC  = 3'd2;
  localparam logic [2:0] OPC_STORE = 3'd3;
  localparam logic [2:0] OPC_CNTR  = 3'd4;
  localparam logic [2:0] OPC_JSR   = 3'd5;
  localparam logic [2:0] OPC_RTS   = 3'd6;
  localparam logic [2:0] OPC_JMP   = 3'd7;

  localparam logic [2:0] ZC_BLANK = 3'd0;
  localparam logic [2:0] ZC_USE_Z = 3'd1;

  typedef enum logic [2:0] {
    OK_VEC  = 3'd0,
    OK_STAT = 3'd1,
    OK_SCAL = 3'd2,
    OK_CNTR = 3'd3,
    OK_HALT = 3'd4
  } op_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_WT0  = 3'd2,
    ST_RD1  = 3'd3,
    ST_WT1  = 3'd4,
    ST_EMIT = 3'd5
  } state_t;

  // Cycle cost of one instruction; scal selects SCAL over STAT for STORE.
  function automatic logic [2:0] inst_len_f(input logic [2:0] opc, input logic scal);
    logic [2:0] len;
    case (opc)
      OPC_VCTR:  len = 3'd7;
      OPC_SVEC:  len = 3'd5;
      OPC_STORE: len = scal ? 3'd2 : 3'd6;
      OPC_CNTR:  len = 3'd4;
      OPC_JMP:   len = 3'd4;
      OPC_JSR:   len = 3'd4;
      OPC_RTS:   len = 3'd3;
      default:   len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/avg_fetch_decode_if.sv
// Vector-memory read port plus decoded-op valid/ready channel.
interface avg_fetch_decode_if #(
  parameter int ADDR_W = 16,
  parameter int DXY_W  = 13
);
  import avg_pkg::*;

  logic                     mem_rd;
  logic [ADDR_W-1:0]        mem_addr;
  logic [15:0]              mem_rdata;
  logic                     op_valid;
  logic                     op_ready;
  op_kind_t                 op_kind;
  logic signed [DXY_W-1:0]  dx;
  logic signed [DXY_W-1:0]  dy;
  logic [3:0]               z_val;
  logic                     blank;
  logic                     use_z;
  logic [2:0]               color;
  logic [7:0]               lin_scale;
  logic [2:0]               bin_scale;
  logic [2:0]               inst_len;

  modport master (
    output mem_rd, mem_addr, op_valid, op_kind, dx, dy, z_val, blank, use_z,
           color, lin_scale, bin_scale, inst_len,
    input  mem_rdata, op_ready
  );

  modport slave (
    input  mem_rd, mem_addr, op_valid, op_kind, dx, dy, z_val, blank, use_z,
           color, lin_scale, bin_scale, inst_len,
    output mem_rdata, op_ready
  );
endinterface

// File: rtl/avg_ret_stack.sv
// LIFO of return addresses for JSR/RTS; caller guarantees no push when full / pop when empty.
module avg_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    stk_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] top;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top     = sp_q - SP_W'(1);
  assign data_o  = empty_o ? '0 : stk_q[top[IDX_W-1:0]];

  // Stack pointer: clear wins, then push, then pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sp_q <= '0;
    else if (clear_i)              sp_q <= '0;
    else if (push_i && !full_o)    sp_q <= sp_q + SP_W'(1);
    else if (pop_i && !empty_o)    sp_q <= sp_q - SP_W'(1);
  end

  // Entry storage, written at the current pointer on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (push_i && !full_o && !clear_i) begin
      stk_q[sp_q[IDX_W-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/avg_fetch_decode.sv
// AVG instruction front end: fetch, flow control, decode and cycle-cost accounting.
//   state | meaning
//   IDLE  | waiting for start
//   RD0   | read strobe for word 0 at pc
//   WT0   | word 0 on mem_rdata; flow ops execute here
//   RD1   | read strobe for VCTR word 1 at pc+1
//   WT1   | word 1 on mem_rdata
//   EMIT  | decoded op presented until accepted
module avg_fetch_decode
  import avg_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4,
  parameter int DXY_W       = 13,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  avg_fetch_decode_if.master bus,
  output logic               busy,
  output logic               halted,
  output logic               stack_err,
  output logic [CNT_W-1:0]   cycle_cnt
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tgt, stk_top;
  logic [15:0]       w0_q, w0_d, w1_q, w1_d;
  logic              halted_q, halted_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    sum;
  logic              push, pop, clr, add_en, stk_full, stk_empty;
  logic [2:0]        add_len, opc_rd, zc;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign tgt    = ADDR_W'(bus.mem_rdata[12:0]);
  assign opc_rd = bus.mem_rdata[15:13];

  avg_ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk(clk), .rst(rst), .clear_i(clr), .push_i(push), .pop_i(pop),
    .data_i(pc_inc), .data_o(stk_top), .full_o(stk_full), .empty_o(stk_empty)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      w0_q     <= '0;
      w1_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: fetch sequencing, flow-op execution, retirement and saturating cost sum.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    halted_d = halted_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    add_en   = 1'b0;
    add_len  = 3'd0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_RD0;
        pc_d     = start_addr;
        halted_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = '0;
        clr      = 1'b1;
      end
      ST_RD0: state_d = ST_WT0;
      ST_WT0: begin
        w0_d    = bus.mem_rdata;
        add_len = inst_len_f(opc_rd, bus.mem_rdata[12]);
        case (opc_rd)
          OPC_VCTR: state_d = ST_RD1;
          OPC_JMP: begin
            pc_d = tgt; add_en = 1'b1; state_d = ST_RD0;
          end
          OPC_JSR: if (stk_full) begin
            err_d = 1'b1; halted_d = 1'b1; state_d = ST_IDLE;
          end else begin
            push = 1'b1; pc_d = tgt; add_en = 1'b1; state_d = ST_RD0;
          end
          OPC_RTS: if (stk_empty) begin
            err_d = 1'b1; halted_d = 1'b1; state_d = ST_IDLE;
          end else begin
            pop = 1'b1; pc_d = stk_top; add_en = 1'b1; state_d = ST_RD0;
          end
          default: state_d = ST_EMIT;
        endcase
      end
      ST_RD1: state_d = ST_WT1;
      ST_WT1: begin
        w1_d    = bus.mem_rdata;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        add_len = inst_len_f(w0_q[15:13], w0_q[12]);
        if (bus.op_ready) begin
          add_en = 1'b1;
          pc_d   = pc_q + ((w0_q[15:13] == OPC_VCTR) ? ADDR_W'(2) : ADDR_W'(1));
          if (w0_q[15:13] == OPC_HALT) begin
            halted_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_RD0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sum = {1'b0, cnt_q} + (CNT_W + 1)'(add_len);
    if (add_en) cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  // Field decode of the held instruction; everything reads 0 outside EMIT.
  always_comb begin
    bus.op_kind   = OK_VEC;
    bus.dx        = '0;
    bus.dy        = '0;
    bus.z_val     = 4'd0;
    bus.blank     = 1'b0;
    bus.use_z     = 1'b0;
    bus.color     = 3'd0;
    bus.lin_scale = 8'd0;
    bus.bin_scale = 3'd0;
    bus.inst_len  = 3'd0;
    zc            = ZC_BLANK;
    if (state_q == ST_EMIT) begin
      bus.inst_len = inst_len_f(w0_q[15:13], w0_q[12]);
      case (w0_q[15:13])
        OPC_VCTR: begin
          bus.dy = DXY_W'($signed(w0_q[12:0]));
          bus.dx = DXY_W'($signed(w1_q[12:0]));
          zc     = w1_q[15:13];
        end
        OPC_SVEC: begin
          bus.dy = DXY_W'($signed(w0_q[12:8]));
          bus.dx = DXY_W'($signed(w0_q[4:0]));
          zc     = w0_q[7:5];
        end
        OPC_STORE: if (w0_q[12]) begin
          bus.op_kind   = OK_SCAL;
          bus.bin_scale = w0_q[10:8];
          bus.lin_scale = w0_q[7:0];
        end else begin
          bus.op_kind = OK_STAT;
          bus.color   = w0_q[10:8];
          bus.z_val   = w0_q[3:0];
        end
        OPC_CNTR: bus.op_kind = OK_CNTR;
        default:  bus.op_kind = OK_HALT;
      endcase
      if (w0_q[15:13] == OPC_VCTR || w0_q[15:13] == OPC_SVEC) begin
        if (zc == ZC_BLANK)      bus.blank = 1'b1;
        else if (zc == ZC_USE_Z) bus.use_z = 1'b1;
        else                     bus.z_val = {zc, 1'b0};
      end
    end
  end

  assign bus.op_valid = (state_q == ST_EMIT);
  assign bus.mem_rd   = (state_q == ST_RD0) || (state_q == ST_RD1);
  assign bus.mem_addr = (state_q == ST_RD0) ? pc_q : ((state_q == ST_RD1) ? pc_inc : '0);
  assign busy         = (state_q != ST_IDLE);
  assign halted       = halted_q;
  assign stack_err    = err_q;
  assign cycle_cnt    = cnt_q;
endmodule

// File: tb/tb_avg_fetch_decode.sv
// Directed and randomized program checks against an instruction-level interpreter.
module tb_avg_fetch_decode;
  import avg_pkg::*;

  localparam int AW = 16, DEPTH = 2, DW = 13, CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, halted, stack_err;
  logic [CW-1:0] cycle_cnt;

  avg_fetch_decode_if #(.ADDR_W(AW), .DXY_W(DW)) bus ();

  avg_fetch_decode #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .DXY_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .bus(bus),
    .busy(busy), .halted(halted), .stack_err(stack_err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  logic [15:0] rdata_q;
  always @(posedge clk) if (bus.mem_rd) rdata_q <= mem[bus.mem_addr];
  assign bus.mem_rdata = rdata_q;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [12:0] dx, dy;
    logic [3:0]  z;
    logic        blank, usez;
    logic [2:0]  color;
    logic [7:0]  lin;
    logic [2:0]  bin;
    logic [2:0]  len;
  } exp_t;

  exp_t          expq[$];
  logic          exp_halted, exp_err;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t zfill(input exp_t e, input logic [2:0] zc);
    exp_t r = e;
    if (zc == 3'd0)      r.blank = 1'b1;
    else if (zc == 3'd1) r.usez = 1'b1;
    else                 r.z = 4'(zc * 2);
    return r;
  endfunction

  // Instruction-level interpreter: walks memory, keeps a return-address list.
  task automatic model(input int unsigned sa);
    int unsigned pc = sa;
    int unsigned stk[$];
    int          cnt = 0;
    int          v;
    logic [15:0] w0, w1;
    exp_t        e;
    expq.delete();
    exp_halted = 1'b0;
    exp_err    = 1'b0;
    for (int step = 0; step < 300 && !exp_halted; step++) begin
      w0 = mem[pc[15:0]];
      e  = '{default: 0};
      case (w0[15:13])
        3'd0: begin
          w1 = mem[(pc + 1) & 32'hFFFF];
          e.kind = OK_VEC; e.dy = w0[12:0]; e.dx = w1[12:0]; e.len = 3'd7;
          e = zfill(e, w1[15:13]);
          expq.push_back(e); cnt += 7; pc = (pc + 2) & 32'hFFFF;
        end
        3'd1: begin
          e.kind = OK_HALT; e.len = 3'd1;
          expq.push_back(e); cnt += 1; exp_halted = 1'b1;
        end
        3'd2: begin
          v = int'(w0[12:8]); if (v >= 16) v -= 32; e.dy = 13'(v);
          v = int'(w0[4:0]);  if (v >= 16) v -= 32; e.dx = 13'(v);
          e.kind = OK_VEC; e.len = 3'd5;
          e = zfill(e, w0[7:5]);
          expq.push_back(e); cnt += 5; pc = (pc + 1) & 32'hFFFF;
        end
        3'd3: begin
          if (w0[12]) begin
            e.kind = OK_SCAL; e.bin = w0[10:8]; e.lin = w0[7:0]; e.len = 3'd2; cnt += 2;
          end else begin
            e.kind = OK_STAT; e.color = w0[10:8]; e.z = w0[3:0]; e.len = 3'd6; cnt += 6;
          end
          expq.push_back(e); pc = (pc + 1) & 32'hFFFF;
        end
        3'd4: begin
          e.kind = OK_CNTR; e.len = 3'd4;
          expq.push_back(e); cnt += 4; pc = (pc + 1) & 32'hFFFF;
        end
        3'd5: begin
          if (stk.size() == DEPTH) begin exp_err = 1'b1; exp_halted = 1'b1; end
          else begin stk.push_back((pc + 1) & 32'hFFFF); pc = int'(w0[12:0]); cnt += 4; end
        end
        3'd6: begin
          if (stk.size() == 0) begin exp_err = 1'b1; exp_halted = 1'b1; end
          else begin pc = stk.pop_back(); cnt += 3; end
        end
        default: begin pc = int'(w0[12:0]); cnt += 4; end
      endcase
    end
    exp_cnt = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
  endtask

  task automatic run(input string name, input logic [15:0] sa, input int hold,
                     input int ready_pct, input int exp_first, input int limit);
    int   cyc = 0, first = -1;
    logic done = 1'b0;
    exp_t e;
    model(sa);
    @(negedge clk);
    start_addr = sa;
    start = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      bus.op_ready = (cyc > hold) && ($urandom_range(99) < ready_pct);
      #1;
      if (bus.op_valid) begin
        if (first < 0) first = cyc;
        chk({name, ":mem_rd_in_emit"}, 32'(bus.mem_rd), 0);
        if (expq.size() == 0) chk({name, ":unexpected_op"}, 1, 0);
        else begin
          e = expq[0];
          chk({name, ":kind"},  32'(bus.op_kind), 32'(e.kind));
          chk({name, ":dx"},    32'($unsigned(bus.dx)), 32'(e.dx));
          chk({name, ":dy"},    32'($unsigned(bus.dy)), 32'(e.dy));
          chk({name, ":z_val"}, 32'(bus.z_val), 32'(e.z));
          chk({name, ":blank"}, 32'(bus.blank), 32'(e.blank));
          chk({name, ":use_z"}, 32'(bus.use_z), 32'(e.usez));
          chk({name, ":color"}, 32'(bus.color), 32'(e.color));
          chk({name, ":lin"},   32'(bus.lin_scale), 32'(e.lin));
          chk({name, ":bin"},   32'(bus.bin_scale), 32'(e.bin));
          chk({name, ":len"},   32'(bus.inst_len), 32'(e.len));
          if (bus.op_ready) void'(expq.pop_front());
        end
      end
      if (!busy) done = 1'b1;
      else if (cyc >= limit) begin chk({name, ":timeout"}, 1, 0); done = 1'b1; end
    end
    bus.op_ready = 1'b0;
    if (exp_first >= 0) chk({name, ":latency"}, 32'(first), 32'(exp_first));
    chk({name, ":ops_left"},  32'(expq.size()), 0);
    chk({name, ":halted"},    32'(halted), 32'(exp_halted));
    chk({name, ":stack_err"}, 32'(stack_err), 32'(exp_err));
    chk({name, ":cycle_cnt"}, 32'(cycle_cnt), 32'(exp_cnt));
  endtask

  task automatic chk_zero(input string name);
    chk({name, ":mem_rd"},    32'(bus.mem_rd), 0);
    chk({name, ":mem_addr"},  32'(bus.mem_addr), 0);
    chk({name, ":op_valid"},  32'(bus.op_valid), 0);
    chk({name, ":op_kind"},   32'(bus.op_kind), 0);
    chk({name, ":dx_dy"},     {6'd0, 13'($unsigned(bus.dx)), 13'($unsigned(bus.dy))}, 0);
    chk({name, ":z_flags"},   {26'd0, bus.z_val, bus.blank, bus.use_z}, 0);
    chk({name, ":scale"},     {18'd0, bus.color, bus.lin_scale, bus.bin_scale}, 0);
    chk({name, ":inst_len"},  32'(bus.inst_len), 0);
    chk({name, ":flags"},     {29'd0, busy, halted, stack_err}, 0);
    chk({name, ":cycle_cnt"}, 32'(cycle_cnt), 0);
  endtask

  task automatic clear_mem(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) mem[i] = 16'h0000;
  endtask

  // Random straight-line program with an optional subroutine call, ending in HALT.
  task automatic gen(input int base);
    int pc = base;
    int sub = base + 'h40;
    int t;
    bit use_sub = ($urandom_range(1) == 1);
    clear_mem(base, base + 'h80);
    for (int k = 0; k < int'($urandom_range(2, 6)); k++) begin
      t = int'($urandom_range(0, 4));
      case (t)
        0: begin mem[pc] = {3'b000, 13'($urandom)}; mem[pc + 1] = 16'($urandom); pc += 2; end
        1: begin mem[pc] = {3'b010, 13'($urandom)}; pc += 1; end
        2: begin mem[pc] = {3'b011, 13'($urandom)}; pc += 1; end
        3: begin mem[pc] = {3'b100, 13'($urandom)}; pc += 1; end
        default: begin
          if (use_sub) mem[pc] = {3'b101, 13'(sub)};
          else         mem[pc] = {3'b010, 13'($urandom)};
          pc += 1;
        end
      endcase
    end
    mem[pc] = {3'b001, 13'($urandom)};
    mem[sub]     = {3'b011, 13'($urandom)};
    mem[sub + 1] = {3'b010, 13'($urandom)};
    mem[sub + 2] = {3'b110, 13'($urandom)};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    bus.op_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    mem[0] = 16'h439E; mem[1] = 16'h2000;
    run("svec", 16'h0000, 0, 100, 3, 50);

    mem['h10] = 16'h0010; mem['h11] = 16'h2005; mem['h12] = 16'h439E; mem['h13] = 16'h2000;
    run("vctr", 16'h0010, 0, 100, 5, 60);

    clear_mem(0, 'h1FF);
    mem[0] = 16'hA100; mem[1] = 16'h2000; mem['h100] = 16'h8000; mem['h101] = 16'hC000;
    run("jsr", 16'h0000, 0, 100, 5, 60);
    chk("jsr:cycle_cnt_12", 32'(cycle_cnt), 12);

    clear_mem(0, 'h1FF);
    mem[0] = 16'hA000;
    run("stack_full", 16'h0000, 0, 100, -1, 60);
    chk("stack_full:err", 32'(stack_err), 1);

    mem['h50] = 16'hC000;
    run("rts_empty", 16'h0050, 0, 100, -1, 60);

    mem['h40] = 16'h6A5C; mem['h41] = 16'h7A5C; mem['h42] = 16'h2000;
    run("backpressure", 16'h0040, 12, 100, 3, 80);

    mem['h60] = 16'hE070; mem['h70] = 16'h8000; mem['h71] = 16'h2000;
    run("jmp", 16'h0060, 0, 100, 5, 60);

    // reset while the VCTR second word is on the bus
    mem[0] = 16'h0010; mem[1] = 16'h2005; mem[2] = 16'h2000;
    @(negedge clk); start_addr = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("rst_wt1");
    @(negedge clk); rst = 1'b0;
    run("after_rst", 16'h0000, 0, 100, 5, 60);

    for (int n = 0; n < 20; n++) begin
      int base = int'($urandom_range('h200, 'h400));
      gen(base);
      run("random", 16'(base), 0, 60, -1, 400);
    end

    // JMP-to-self loop: cost saturates; a start while busy is ignored
    mem['h80] = 16'hE080;
    @(negedge clk); start_addr = 16'h0080; start = 1'b1;
    for (int cyc = 1; cyc <= 33000; cyc++) begin
      @(negedge clk);
      start = (cyc == 50);
      if (cyc == 50) start_addr = 16'h0010;
      #1;
      if (cyc == 101) begin
        chk("sat:cnt_mid", 32'(cycle_cnt), 32'(((101 - 1) / 2) * 4));
        chk("sat:busy", 32'(busy), 1);
      end
    end
    chk("sat:cnt_full", 32'(cycle_cnt), 32'h0000FFFF);
    chk("sat:err", 32'(stack_err), 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
